// File: rtl/lock_pkg.sv
// Shared constants, FSM state type and a small priority helper for the keypad entry block.
package lock_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [3:0] ROW_IDLE = 4'b1110;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HOLD     = 2'd2,
    ST_RELEASE  = 2'd3
  } state_e;

  // Index of the lowest-numbered zero bit; serves both column pick and one-hot-low row decode.
  function automatic logic [1:0] low_index(input logic [3:0] v);
    if (!v[0])      return 2'd0;
    else if (!v[1]) return 2'd1;
    else if (!v[2]) return 2'd2;
    else            return 2'd3;
  endfunction

endpackage

// File: rtl/key_sync.sv
// Two-flop synchroniser for an asynchronous input; RISE=1 turns the output into a rising-edge pulse.
module key_sync #(
  parameter int         W    = 1,
  parameter logic [W-1:0] IDLE = '0,
  parameter bit         RISE = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] async_in,
  output logic [W-1:0] sync_out
);

  logic [W-1:0] meta_q, meta_d;
  logic [W-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = async_in;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= IDLE;
      sync_q <= IDLE;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  generate
    if (RISE) begin : g_rise
      logic [W-1:0] prev_q, prev_d;
      assign prev_d = sync_q;
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) prev_q <= IDLE;
        else        prev_q <= prev_d;
      end
      assign sync_out = sync_q & ~prev_q;
    end else begin : g_level
      assign sync_out = sync_q;
    end
  endgenerate

endmodule

// File: rtl/keypad_entry.sv
// 4x4 keypad scanner with debounce and a DIGITS-long hex code buffer.
// Optional entry timeout is compiled in with KEYPAD_ENTRY_TIMEOUT_EN.
module keypad_entry
  import lock_pkg::*;
#(
  parameter int DIGITS          = 4,
  parameter int SCAN_DIV        = 8,
  parameter int DEBOUNCE_CYCLES = 16
`ifdef KEYPAD_ENTRY_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1_000_000
`endif
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [3:0]                    key_col,
  output logic [3:0]                    key_row,
  input  logic                          enter,
  input  logic                          clear,
  output logic [DIGIT_W*DIGITS-1:0]     code,
  output logic                          code_valid,
  output logic                          entry_err,
  output logic [$clog2(DIGITS+1)-1:0]   digit_cnt,
  output logic                          entry_ovf
);

  localparam int CODE_W = DIGIT_W * DIGITS;
  localparam int CNT_W  = $clog2(DIGITS + 1);
  localparam int DIV_W  = $clog2(SCAN_DIV + 1);
  localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] FULL     = CNT_W'(DIGITS);
`ifdef KEYPAD_ENTRY_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
`endif

  logic [3:0] col_s;
  logic       enter_rise, clear_rise;

  key_sync #(.W(4), .IDLE(4'hF), .RISE(1'b0)) u_sync_col (
    .clk(clk), .reset(reset), .async_in(key_col), .sync_out(col_s)
  );
  key_sync #(.W(1), .IDLE(1'b0), .RISE(1'b1)) u_sync_enter (
    .clk(clk), .reset(reset), .async_in(enter), .sync_out(enter_rise)
  );
  key_sync #(.W(1), .IDLE(1'b0), .RISE(1'b1)) u_sync_clear (
    .clk(clk), .reset(reset), .async_in(clear), .sync_out(clear_rise)
  );

  state_e              state_q, state_d;
  logic [3:0]          row_q, row_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [1:0]          col_idx_q, col_idx_d;
  logic [DEB_W-1:0]    deb_q, deb_d;
  logic                accept;
  logic [DIGIT_W-1:0]  digit;

  logic [CODE_W-1:0]   buf_q, buf_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic                valid_q, valid_d;
  logic                err_q, err_d;
`ifdef KEYPAD_ENTRY_TIMEOUT_EN
  logic [TMO_W-1:0]    tmo_q, tmo_d;
`endif

  // The frozen row is one-hot-low, so the same priority helper decodes it.
  assign digit = {low_index(row_q), col_idx_q};

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    div_d     = div_q;
    col_idx_d = col_idx_q;
    deb_d     = deb_q;
    accept    = 1'b0;
    case (state_q)
      ST_SCAN: begin
        if (col_s != 4'hF) begin
          col_idx_d = low_index(col_s);
          deb_d     = '0;
          state_d   = ST_DEBOUNCE;
        end else if (div_q == DIV_LAST) begin
          div_d = '0;
          row_d = {row_q[2:0], row_q[3]};
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      ST_DEBOUNCE: begin
        if (!col_s[col_idx_q]) begin
          if (deb_q == DEB_LAST) begin
            accept  = 1'b1;
            deb_d   = '0;
            state_d = ST_HOLD;
          end else begin
            deb_d = deb_q + 1'b1;
          end
        end else begin
          deb_d   = '0;
          div_d   = '0;
          state_d = ST_SCAN;
        end
      end
      ST_HOLD: begin
        if (col_s == 4'hF) begin
          deb_d   = '0;
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (col_s != 4'hF) begin
          state_d = ST_HOLD;
        end else if (deb_q == DEB_LAST) begin
          deb_d   = '0;
          div_d   = '0;
          state_d = ST_SCAN;
        end else begin
          deb_d = deb_q + 1'b1;
        end
      end
      default: state_d = ST_SCAN;
    endcase
  end

  // Event priority: clear, then enter, then digit accept (then timeout when built in).
  always_comb begin
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    code_d  = '0;
    valid_d = 1'b0;
    err_d   = 1'b0;
`ifdef KEYPAD_ENTRY_TIMEOUT_EN
    tmo_d   = '0;
`endif
    if (clear_rise) begin
      buf_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (enter_rise) begin
      if (cnt_q == FULL) begin
        valid_d = 1'b1;
        code_d  = buf_q;
      end else begin
        err_d = 1'b1;
      end
      buf_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (accept) begin
      if (cnt_q == FULL) begin
        ovf_d = 1'b1;
      end else begin
        buf_d = (buf_q << DIGIT_W) | CODE_W'(digit);
        cnt_d = cnt_q + 1'b1;
      end
    end
`ifdef KEYPAD_ENTRY_TIMEOUT_EN
    else if (cnt_q != '0 && cnt_q != FULL) begin
      if (tmo_q == TMO_LAST) begin
        buf_d = '0;
        cnt_d = '0;
        err_d = 1'b1;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_SCAN;
      row_q     <= ROW_IDLE;
      div_q     <= '0;
      col_idx_q <= '0;
      deb_q     <= '0;
      buf_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      code_q    <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
`ifdef KEYPAD_ENTRY_TIMEOUT_EN
      tmo_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      div_q     <= div_d;
      col_idx_q <= col_idx_d;
      deb_q     <= deb_d;
      buf_q     <= buf_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
`ifdef KEYPAD_ENTRY_TIMEOUT_EN
      tmo_q     <= tmo_d;
`endif
    end
  end

  assign key_row    = row_q;
  assign code       = code_q;
  assign code_valid = valid_q;
  assign entry_err  = err_q;
  assign digit_cnt  = cnt_q;
  assign entry_ovf  = ovf_q;

endmodule

// File: tb/tb_keypad_entry.sv
// Bench for keypad_entry: a keypad model driven by directed and random key presses, checked against a digit-queue model.
module tb_keypad_entry;

  localparam int DIGITS = 4;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [3:0]            key_col;
  logic [3:0]            key_row;
  logic                  enter;
  logic                  clear;
  logic [4*DIGITS-1:0]   code;
  logic                  code_valid;
  logic                  entry_err;
  logic [2:0]            digit_cnt;
  logic                  entry_ovf;

  int checks    = 0;
  int failures  = 0;
  int strays    = 0;
  int zero_viol = 0;

  logic       key_dn;
  int         key_r, key_c;
  logic       force_en;
  logic [3:0] force_val;

  int model_q[$];
  bit model_ovf;

  always #5 clk = ~clk;

  // A held key pulls its column low only while its row is driven low.
  assign key_col = force_en ? force_val :
                   (key_dn && key_row[key_r[1:0]] == 1'b0) ? ~(4'b0001 << key_c[1:0]) : 4'hF;

  keypad_entry #(.DIGITS(DIGITS), .SCAN_DIV(8), .DEBOUNCE_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .key_col(key_col), .key_row(key_row),
    .enter(enter), .clear(clear), .code(code), .code_valid(code_valid),
    .entry_err(entry_err), .digit_cnt(digit_cnt), .entry_ovf(entry_ovf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      if (code_valid || entry_err) strays++;
      if (!code_valid && code != '0) zero_viol++;
    end
  endtask

  function automatic logic [15:0] model_code();
    logic [15:0] v = '0;
    foreach (model_q[i]) v = (v << 4) | 16'(model_q[i]);
    return v;
  endfunction

  task automatic model_digit(input int r, input int c);
    if (model_q.size() < DIGITS) model_q.push_back(r * 4 + c);
    else model_ovf = 1'b1;
  endtask

  task automatic press(input int r, input int c);
    key_r = r; key_c = c; key_dn = 1'b1;
    tick(120);
    key_dn = 1'b0;
    tick(60);
    model_digit(r, c);
    check("digit_cnt_after_press", digit_cnt, model_q.size());
    check("entry_ovf_after_press", entry_ovf, model_ovf);
  endtask

  task automatic press_random(input int n);
    for (int k = 0; k < n; k++) press($urandom_range(0, 3), $urandom_range(0, 3));
  endtask

  task automatic do_enter(input bit with_clear);
    int          nv = 0;
    int          ne = 0;
    logic [15:0] got = '0;
    bit          full = (model_q.size() == DIGITS);
    logic [15:0] exp = model_code();
    enter = 1'b1;
    if (with_clear) clear = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (code_valid) begin nv++; got = code; end
      if (entry_err) ne++;
      if (!code_valid && code != '0) zero_viol++;
      if (i == 3) begin enter = 1'b0; clear = 1'b0; end
    end
    if (with_clear) begin
      check("clear_enter_valid", nv, 0);
      check("clear_enter_err", ne, 0);
    end else begin
      check("enter_valid_pulses", nv, full ? 1 : 0);
      check("enter_err_pulses", ne, full ? 0 : 1);
      if (full) check("enter_code", got, exp);
    end
    model_q.delete();
    model_ovf = 1'b0;
    check("digit_cnt_after_enter", digit_cnt, 0);
    check("entry_ovf_after_enter", entry_ovf, 0);
  endtask

  task automatic clear_pulse();
    clear = 1'b1;
    tick(4);
    clear = 1'b0;
    tick(4);
    model_q.delete();
    model_ovf = 1'b0;
    check("digit_cnt_after_clear", digit_cnt, 0);
    check("entry_ovf_after_clear", entry_ovf, 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_key_row"}, key_row, 4'b1110);
    check({tag, "_code"}, code, 0);
    check({tag, "_code_valid"}, code_valid, 0);
    check({tag, "_entry_err"}, entry_err, 0);
    check({tag, "_digit_cnt"}, digit_cnt, 0);
    check({tag, "_entry_ovf"}, entry_ovf, 0);
  endtask

  initial begin
    reset = 1'b0; enter = 1'b0; clear = 1'b0;
    key_dn = 1'b0; key_r = 0; key_c = 0;
    force_en = 1'b0; force_val = 4'hF;
    model_ovf = 1'b0;
    tick(3);
    check_reset_vals("reset");
    reset = 1'b1;
    tick(4);
    check_reset_vals("post_reset");

    // Four digits 1,1,1,6 then enter
    press(0, 1); press(0, 1); press(0, 1); press(1, 2);
    do_enter(1'b0);

    // Short bounce on column 1 must not register
    force_en = 1'b1; force_val = 4'b1101;
    tick(10);
    force_val = 4'hF;
    tick(40);
    force_en = 1'b0;
    check("bounce_digit_cnt", digit_cnt, 0);
    check("bounce_entry_ovf", entry_ovf, 0);

    // Partial entry then enter
    press_random(3);
    do_enter(1'b0);

    // Overflow: digits 1..5 then enter
    press(0, 1); press(0, 2); press(0, 3); press(1, 0); press(1, 1);
    do_enter(1'b0);

    // Clear and enter together on a full buffer
    press_random(4);
    do_enter(1'b1);

    // Clear mid-entry
    press_random(2);
    clear_pulse();

    // Reset mid-entry with a key still held across deassertion
    press_random(2);
    key_r = $urandom_range(0, 3); key_c = $urandom_range(0, 3); key_dn = 1'b1;
    tick(10);
    reset = 1'b0;
    tick(2);
    check_reset_vals("mid_reset");
    reset = 1'b1;
    model_q.delete();
    model_ovf = 1'b0;
    tick(110);
    key_dn = 1'b0;
    tick(60);
    model_digit(key_r, key_c);
    check("held_key_redebounce", digit_cnt, model_q.size());
    press_random(3);
    do_enter(1'b0);

    // Random rounds of entries finished by enter or clear
    for (int round = 0; round < 6; round++) begin
      press_random($urandom_range(0, 6));
      if ($urandom_range(0, 3) != 0) do_enter(1'b0);
      else clear_pulse();
    end

    check("no_stray_pulses", strays, 0);
    check("code_zero_when_idle", zero_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
